pattern_detect: RTL and testbench
=================================

PATTERN_DETECT -- requirements
Module: pattern_detect

Interface
REQ-001 Parameter SYM_W, default 2, width of one input symbol in bits.
REQ-002 Parameter PAT_LEN, default 3, number of symbols in the pattern (range 1..16).
REQ-003 Parameter CNT_W, default 8, width of the match counter.
REQ-004 Parameter DEF_PATTERN, default 6'b01_10_11, reset value of the pattern register (PAT_LEN*SYM_W bits).
REQ-005 clk  input  1  single system clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  in_sym is sampled only when high.
REQ-008 in_sym  input  SYM_W  input symbol.
REQ-009 cfg_we  input  1  loads cfg_pattern into the pattern register.
REQ-010 cfg_pattern  input  PAT_LEN*SYM_W  new pattern; bits [PAT_LEN*SYM_W-1 -: SYM_W] are the first symbol.
REQ-011 cfg_overlap  input  1  live mode bit: 1 = overlapping matches allowed.
REQ-012 cfg_hold  input  1  live mode bit: 1 = match held while the last pattern symbol repeats.
REQ-013 cnt_clr  input  1  clears match_cnt.
REQ-014 match  output  1  registered detect flag.
REQ-015 match_cnt  output  CNT_W  count of fresh matches, saturating.

Function
REQ-016 The block SHALL keep a history shift register of the last PAT_LEN accepted symbols plus a fill counter (0..PAT_LEN).
REQ-017 A symbol is accepted when in_valid=1 and cfg_we=0; on acceptance history shifts by one symbol, with the newest symbol in the lowest slot, and fill increments, saturating at PAT_LEN.
REQ-018 A fresh match SHALL occur on an accepted symbol when the updated fill equals PAT_LEN and the updated history equals the pattern register.
REQ-019 The FSM SHALL have states FILL (fill<PAT_LEN), ARMED (fill==PAT_LEN, not held) and HELD.
REQ-020 On a fresh match: match<=1, match_cnt increments; the next state is HELD if cfg_hold=1, otherwise ARMED.
REQ-021 On a fresh match with cfg_overlap=0, fill SHALL be cleared to 0 (next state FILL, or HELD if cfg_hold=1); with cfg_overlap=1 the history is retained.
REQ-022 In HELD, an accepted symbol equal to the last pattern symbol that is not a fresh match SHALL keep match=1 without incrementing match_cnt.
REQ-023 In HELD, any other accepted symbol SHALL set match<=0 and leave HELD; the symbol is still shifted into history and evaluated per REQ-018.
REQ-024 In ARMED or FILL, an accepted symbol that is not a fresh match SHALL set match<=0.
REQ-025 When no symbol is accepted, match, history, fill and state SHALL hold.
REQ-026 Latency: match reflects the symbol accepted at edge k during the cycle after edge k (one register stage).
REQ-027 cfg_we=1 SHALL load the pattern, clear fill, match and HELD, and discard any same-cycle in_sym; match_cnt is unchanged.
REQ-028 match_cnt SHALL saturate at 2^CNT_W-1.
REQ-029 cnt_clr SHALL set match_cnt to 0 and wins over a same-cycle increment.
REQ-030 Changing cfg_overlap or cfg_hold takes effect at the next accepted symbol; no state is retroactively altered.

Reset
REQ-031 reset=1 at a clock edge SHALL set the pattern to DEF_PATTERN, fill to 0, state to FILL, match to 0 and match_cnt to 0, overriding all other inputs.
REQ-032 Reset asserted mid-sequence SHALL discard partial history; no match may result from symbols accepted before reset.

Verification
REQ-033 Defaults, hold=0: feed valid 1,2,3 -> match=1 for exactly one cycle after the 3rd symbol; match_cnt=1.
REQ-034 hold=1: feed 1,2,3,3,3,0 -> match high for 3 cycles, then 0; match_cnt=1. hold=0, same stream -> match high for 1 cycle.
REQ-035 Load cfg_pattern=6'b01_01_01, feed 1,1,1,1 -> overlap=1: match on the 3rd and 4th symbols, match_cnt=2; overlap=0: match on the 3rd only, match_cnt=1.
REQ-036 Feed 1, idle, 2, idle, idle, 3 (in_valid gaps) -> match asserted after the 3; match stays 0 during idle cycles.
REQ-037 Feed 1,2, then assert reset, then 3 -> no match; the pattern is DEF_PATTERN again.
REQ-038 CNT_W=2: produce 4 fresh matches -> match_cnt=3 (saturated); assert cnt_clr in the same cycle as a fresh match -> match_cnt=0 while match=1.

Source files
------------

// File: rtl/pattern_detect.sv
// pattern_detect
//   Watches a stream of SYM_W-bit symbols and flags every occurrence of a
//   programmable PAT_LEN-symbol pattern. Fresh matches are counted in a
//   saturating counter. Overlapping matches and "hold while the last symbol
//   repeats" behaviour are selected live by cfg_overlap / cfg_hold.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   in_valid     in   in_sym is accepted when high (and cfg_we is low)
//   in_sym       in   SYM_W  input symbol
//   cfg_we       in   load cfg_pattern, restart detection
//   cfg_pattern  in   PAT_LEN*SYM_W  new pattern, first symbol in the MSBs
//   cfg_overlap  in   1 = overlapping matches allowed
//   cfg_hold     in   1 = keep match high while the last symbol repeats
//   cnt_clr      in   clear match_cnt (wins over an increment)
//   match        out  registered detect flag
//   match_cnt    out  CNT_W  saturating count of fresh matches
module pattern_detect #(
    parameter int                           SYM_W       = 2,
    parameter int                           PAT_LEN     = 3,
    parameter int                           CNT_W       = 8,
    parameter logic [PAT_LEN*SYM_W-1:0]     DEF_PATTERN = 6'b01_10_11
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [SYM_W-1:0]            in_sym,
    input  logic                        cfg_we,
    input  logic [PAT_LEN*SYM_W-1:0]    cfg_pattern,
    input  logic                        cfg_overlap,
    input  logic                        cfg_hold,
    input  logic                        cnt_clr,
    output logic                        match,
    output logic [CNT_W-1:0]            match_cnt
);

    localparam int                PW     = PAT_LEN * SYM_W;
    localparam int                FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ARMED = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      pat_q,   pat_d;
    logic [PW-1:0]      hist_q,  hist_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               accept;
    logic [PW-1:0]      hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               fresh;
    logic               hold_rpt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // A pattern load steals the cycle: the same-cycle symbol is dropped.
    assign accept = in_valid & ~cfg_we;

    // Newest symbol enters the lowest slot, so the oldest one lines up with
    // the first pattern symbol in the MSBs.
    if (PAT_LEN == 1) begin : g_hist_one
        assign hist_shift = in_sym;
    end else begin : g_hist_many
        assign hist_shift = {hist_q[PW-SYM_W-1:0], in_sym};
    end

    assign fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    assign fresh    = accept && (fill_inc == FULL) && (hist_shift == pat_q);
    // Repeat of the final pattern symbol while held keeps the flag up.
    assign hold_rpt = (state_q == S_HELD) && accept && !fresh
                      && (in_sym == pat_q[SYM_W-1:0]);

    always_comb begin
        pat_d  = cfg_we ? cfg_pattern : pat_q;
        hist_d = accept ? hist_shift : hist_q;
        fill_d = fill_q;
        if (cfg_we) begin
            fill_d = '0;
        end else if (accept) begin
            // Without overlap a match consumes its symbols.
            fill_d = (fresh && !cfg_overlap) ? '0 : fill_inc;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (cfg_we) begin
            state_d = S_FILL;
        end else if (accept) begin
            if ((fresh && cfg_hold) || hold_rpt) begin
                state_d = S_HELD;
            end else if (fill_d == FULL) begin
                state_d = S_ARMED;
            end else begin
                state_d = S_FILL;
            end
        end
    end

    // Output logic
    always_comb begin
        match_d = match_q;
        if (cfg_we) begin
            match_d = 1'b0;
        end else if (accept) begin
            match_d = fresh | hold_rpt;
        end

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (fresh) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            pat_q   <= DEF_PATTERN;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    // History is only meaningful under fill, so it needs no reset.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_detect.sv
// Testbench for pattern_detect: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a queue-based model.
module tb_pattern_detect;

    localparam int           SYM_W   = 2;
    localparam int           PAT_LEN = 3;
    localparam int           CNT_W   = 2;
    localparam int           PW      = PAT_LEN * SYM_W;
    localparam logic [PW-1:0] DEF    = 6'b01_10_11;
    localparam int           CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [SYM_W-1:0] in_sym;
    logic             cfg_we;
    logic [PW-1:0]    cfg_pattern;
    logic             cfg_overlap;
    logic             cfg_hold;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;

    always #5 clk = ~clk;

    pattern_detect #(
        .SYM_W      (SYM_W),
        .PAT_LEN    (PAT_LEN),
        .CNT_W      (CNT_W),
        .DEF_PATTERN(DEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sym     (in_sym),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap),
        .cfg_hold   (cfg_hold),
        .cnt_clr    (cnt_clr),
        .match      (match),
        .match_cnt  (match_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: pattern as a list of symbols, a window of the symbols
    // accepted since detection last restarted, a held flag and the outputs.
    int pat[PAT_LEN];
    int win[$];
    bit held;
    bit m_match;
    int m_cnt;

    function automatic void load_pat(input logic [PW-1:0] p);
        for (int i = 0; i < PAT_LEN; i++) pat[i] = int'(p[PW-1-i*SYM_W -: SYM_W]);
    endfunction

    function automatic void model_step();
        bit fresh;
        fresh = 1'b0;
        if (reset) begin
            load_pat(DEF);
            win.delete();
            held = 1'b0; m_match = 1'b0; m_cnt = 0;
            return;
        end
        if (cfg_we) begin
            load_pat(cfg_pattern);
            win.delete();
            held = 1'b0; m_match = 1'b0;
        end else if (in_valid) begin
            win.push_back(int'(in_sym));
            if (win.size() > PAT_LEN) void'(win.pop_front());
            if (win.size() == PAT_LEN) begin
                fresh = 1'b1;
                for (int i = 0; i < PAT_LEN; i++) if (win[i] != pat[i]) fresh = 1'b0;
            end
            if (fresh) begin
                m_match = 1'b1;
                held    = cfg_hold;
                if (!cfg_overlap) win.delete();
            end else if (held && int'(in_sym) == pat[PAT_LEN-1]) begin
                m_match = 1'b1;
            end else begin
                m_match = 1'b0;
                held    = 1'b0;
            end
        end
        if (cnt_clr) m_cnt = 0;
        else if (fresh && m_cnt < CNT_MAX) m_cnt++;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (match !== m_match) begin
                errors++;
                $display("FAIL cyc_match t=%0t dut=%0b model=%0b", $time, match, m_match);
            end
            checks++;
            if (match_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL cyc_cnt t=%0t dut=%0d model=%0d", $time, match_cnt, m_cnt);
            end
        end
    end

    task automatic cycle(input bit r, input bit v, input int s, input bit we,
                         input logic [PW-1:0] cp, input bit clr);
        reset = r; in_valid = v; in_sym = SYM_W'(s); cfg_we = we;
        cfg_pattern = cp; cnt_clr = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic feed(input int s);
        cycle(1'b0, 1'b1, s, 1'b0, '0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic load(input logic [PW-1:0] p);
        cycle(1'b0, 1'b0, 0, 1'b1, p, 1'b0);
    endtask

    // Hand-computed expectation, applied to both the DUT and the model.
    task automatic expect_out(input string name, input bit em, input int ec);
        checks++;
        if (match !== em) begin
            errors++;
            $display("FAIL %s match: dut=%0b want=%0b", name, match, em);
        end
        checks++;
        if (match_cnt !== CNT_W'(ec)) begin
            errors++;
            $display("FAIL %s cnt: dut=%0d want=%0d", name, match_cnt, ec);
        end
        checks++;
        if (m_match != em || m_cnt != ec) begin
            errors++;
            $display("FAIL %s model: match=%0b cnt=%0d want %0b/%0d", name, m_match, m_cnt, em, ec);
        end
    endtask

    bit               rr, rv, rwe, rclr;
    int               rs;
    logic [PW-1:0]    rcp;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sym = '0; cfg_we = 1'b0;
        cfg_pattern = '0; cfg_overlap = 1'b0; cfg_hold = 1'b0; cnt_clr = 1'b0;
        do_reset(); do_reset();
        chk_en = 1'b1;
        expect_out("reset", 1'b0, 0);

        // Default pattern, no hold: single-cycle match.
        feed(1); feed(2); feed(3);
        expect_out("basic_hit", 1'b1, 1);
        feed(0);
        expect_out("basic_drop", 1'b0, 1);

        // Hold: match stays up over repeated last symbol.
        do_reset(); cfg_hold = 1'b1;
        feed(1); feed(2); feed(3);
        expect_out("hold_hit", 1'b1, 1);
        feed(3); expect_out("hold_rpt1", 1'b1, 1);
        feed(3); expect_out("hold_rpt2", 1'b1, 1);
        feed(0); expect_out("hold_exit", 1'b0, 1);
        do_reset(); cfg_hold = 1'b0;
        feed(1); feed(2); feed(3); feed(3);
        expect_out("nohold_rpt", 1'b0, 1);

        // Overlap on a self-overlapping pattern.
        do_reset(); cfg_overlap = 1'b1;
        load(6'b01_01_01);
        feed(1); feed(1);
        expect_out("ovl_pre", 1'b0, 0);
        feed(1); expect_out("ovl_3rd", 1'b1, 1);
        feed(1); expect_out("ovl_4th", 1'b1, 2);
        do_reset(); cfg_overlap = 1'b0;
        load(6'b01_01_01);
        feed(1); feed(1); feed(1);
        expect_out("novl_3rd", 1'b1, 1);
        feed(1); expect_out("novl_4th", 1'b0, 1);

        // Pattern load clears match, keeps the count.
        feed(1); feed(1);
        expect_out("novl_again", 1'b1, 2);
        load(DEF);
        expect_out("load_clr", 1'b0, 2);

        // Gaps in in_valid.
        do_reset();
        feed(1); idle(); expect_out("gap1", 1'b0, 0);
        feed(2); idle(); idle(); expect_out("gap2", 1'b0, 0);
        feed(3); expect_out("gap_hit", 1'b1, 1);
        idle(); expect_out("gap_keep", 1'b1, 1);

        // Reset discards partial history and restores the default pattern.
        load(6'b00_00_00);
        feed(1); feed(2);
        do_reset();
        feed(3); expect_out("rst_nohit", 1'b0, 0);
        feed(1); feed(2); feed(3);
        expect_out("rst_defpat", 1'b1, 1);

        // Counter saturation and clear-vs-increment priority.
        do_reset(); cfg_overlap = 1'b1;
        for (int k = 0; k < 4; k++) begin feed(1); feed(2); feed(3); end
        expect_out("cnt_sat", 1'b1, 3);
        feed(1); feed(2);
        cycle(1'b0, 1'b1, 3, 1'b0, '0, 1'b1);
        expect_out("cnt_clr_hit", 1'b1, 0);

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) cfg_hold = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) cfg_overlap = ~cfg_overlap;
            rr   = ($urandom_range(0, 299) == 0);
            rwe  = ($urandom_range(0, 59) == 0);
            rv   = ($urandom_range(0, 9) < 7);
            rclr = ($urandom_range(0, 29) == 0);
            rcp  = PW'($urandom_range(0, (1 << PW) - 1));
            case ($urandom_range(0, 3))
                0, 1:    rs = pat[win.size() % PAT_LEN];
                2:       rs = pat[PAT_LEN-1];
                default: rs = $urandom_range(0, (1 << SYM_W) - 1);
            endcase
            cycle(rr, rv, rs, rwe, rcp, rclr);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
